// File: rtl/countones_pkg.sv
// Shared types for the population-count monitor.
// Also carries a behavioural popcount helper for benches.
package countones_pkg;

    typedef enum logic [1:0] {
        ONEHOT  = 2'd0,
        ONEHOT0 = 2'd1,
        EXACT   = 2'd2,
        ATMOST  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FAILING = 2'd1,
        ALARM   = 2'd2
    } state_e;

    function automatic int popcount_f(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/countones_monitor_popcount_tree.sv
// Combinational popcount of a WIDTH-bit vector.
// Result width is just wide enough to hold WIDTH.
module popcount_tree #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CW-1:0]    cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/countones_monitor.sv
// Population-count invariant checker with stats, first-fail capture and alarm FSM.
// Define COUNTONES_MON_SVA_EN to embed concurrent assertions.
module countones_monitor
    import countones_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int CNT_W     = 16,
    parameter  int ALARM_THR = 3,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] vec,
    input  logic [1:0]       mode,
    input  logic [CW-1:0]    target,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic [CW-1:0]    popcnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [WIDTH-1:0] first_fail_vec,
    output logic             first_fail_vld,
    output logic             alarm,
    output logic [1:0]       state
);

    localparam int             CNW = $clog2(ALARM_THR + 1);
    localparam logic [CNW-1:0] THR = CNW'(ALARM_THR);

    logic [CW-1:0]  pc;
    logic           ok;
    logic           smp;
    logic           pass_now;
    logic           fail_now;
    state_e         state_q;
    state_e         state_nx;
    logic [CNW-1:0] consec_q;
    logic [CNW-1:0] consec_nx;

    popcount_tree #(.WIDTH(WIDTH)) u_pc (
        .vec (vec),
        .cnt (pc)
    );

    always_comb begin
        ok = 1'b0;
        unique case (mode_e'(mode))
            ONEHOT:  ok = (pc == CW'(1));
            ONEHOT0: ok = (pc <= CW'(1));
            EXACT:   ok = (pc == target);
            ATMOST:  ok = (pc <= target);
            default: ok = 1'b0;
        endcase
    end

    // clr discards any sample presented alongside it
    assign smp      = sample_en && !clr;
    assign pass_now = smp && ok;
    assign fail_now = smp && !ok;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            pass_pulse     <= 1'b0;
            fail_pulse     <= 1'b0;
            popcnt         <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            pass_pulse <= pass_now;
            fail_pulse <= fail_now;
            if (smp) popcnt <= pc;
            if (pass_now && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            if (fail_now && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            if (fail_now && !first_fail_vld) begin
                first_fail_vec <= vec;
                first_fail_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state_q  <= IDLE;
            consec_q <= '0;
        end else begin
            state_q  <= state_nx;
            consec_q <= consec_nx;
        end
    end

    always_comb begin
        state_nx  = state_q;
        consec_nx = consec_q;
        if (smp) begin
            unique case (state_q)
                IDLE: begin
                    if (!ok) begin
                        consec_nx = CNW'(1);
                        state_nx  = (ALARM_THR == 1) ? ALARM : FAILING;
                    end
                end
                FAILING: begin
                    if (!ok) begin
                        consec_nx = consec_q + 1'b1;
                        if (consec_nx == THR) state_nx = ALARM;
                    end else begin
                        consec_nx = '0;
                        state_nx  = IDLE;
                    end
                end
                ALARM:   state_nx = ALARM;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        alarm = (state_q == ALARM);
        state = state_q;
    end

`ifdef COUNTONES_MON_SVA_EN
    a_excl: assert property (@(posedge clk) disable iff (!rst_n)
        fail_pulse |-> !pass_pulse);
    a_rose: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(alarm) |-> $past(fail_now));
    a_stick: assert property (@(posedge clk) disable iff (!rst_n)
        (alarm && !clr) |=> alarm);
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (sample_en && !clr && mode_e'(mode) == ONEHOT)
        |=> pass_pulse == $past($onehot(vec)));
`endif

endmodule
